// File: rtl/fu_mdu.sv
// fu_mdu: iterative RV32M multiply/divide unit on the INTM issue path.
// One operation in flight; 33-cycle issue-to-result latency
// (1 cycle for divide by zero). The result is a single-cycle CDB pulse.

package cpu_params;
  localparam int ROB_IDX = 5;
  localparam int PRF_IDX = 6;
  localparam int ARF_IDX = 5;

  // RV32M funct3 order: bit 2 selects divide, bit 1 selects REM within divide
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } mdopc_t;

  typedef struct packed {
    logic [ROB_IDX-1:0] rob_id;
    logic [ARF_IDX-1:0] rd_arch;
    logic [PRF_IDX-1:0] rd_phy;
    mdopc_t             fu_opcode;
    logic [31:0]        rs1_value;
    logic [31:0]        rs2_value;
  } intm_rs_reg_t;

  typedef struct packed {
    logic [ROB_IDX-1:0] rob_id;
    logic [ARF_IDX-1:0] rd_arch;
    logic [PRF_IDX-1:0] rd_phy;
    logic [31:0]        rd_value;
    logic [31:0]        rs1_value_dbg;
    logic [31:0]        rs2_value_dbg;
  } fu_cdb_reg_t;
endpackage

module fu_mdu
  import cpu_params::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         issue_valid,
  output logic         issue_ready,
  input  intm_rs_reg_t issue_pkt,
  output logic         cdb_valid,
  output fu_cdb_reg_t  cdb_out
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t       state;
  logic [4:0]   cnt;
  logic [63:0]  acc;      // multiply accumulator
  logic [63:0]  mcand;    // multiplicand, shifted left each iteration
  logic [31:0]  opb;      // multiplier (shifts right) or dividend/quotient (shifts left)
  logic [31:0]  prem;     // divide partial remainder
  logic [31:0]  dsr;      // divisor magnitude
  logic         neg_res;  // negate product / quotient
  logic         neg_rem;  // negate remainder
  intm_rs_reg_t pkt;

  logic         accept;
  logic         is_div;
  logic         div_zero;
  logic         s1;
  logic         s2;
  logic [31:0]  mag1;
  logic [31:0]  mag2;
  logic [31:0]  dz_value;

  logic [63:0]  acc_nxt;
  logic [63:0]  prod_fin;
  logic [32:0]  rem_sh;
  logic         q_bit;
  logic [31:0]  rem_nxt;
  logic [31:0]  quo_nxt;
  logic [31:0]  quo_fin;
  logic [31:0]  rem_fin;

  function automatic fu_cdb_reg_t make_cdb(input intm_rs_reg_t p, input logic [31:0] value);
    fu_cdb_reg_t c;
    c.rob_id        = p.rob_id;
    c.rd_arch       = p.rd_arch;
    c.rd_phy        = p.rd_phy;
    c.rd_value      = value;
    c.rs1_value_dbg = p.rs1_value;
    c.rs2_value_dbg = p.rs2_value;
    return c;
  endfunction

  // Accept-time decode: operand signedness, magnitudes and divide-by-zero bypass value
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    accept   = issue_valid & issue_ready;
    is_div   = issue_pkt.fu_opcode[2];
    div_zero = (issue_pkt.rs2_value == 32'd0);
    s1       = 1'b0;
    s2       = 1'b0;
    case (issue_pkt.fu_opcode)
      MD_MULH, MD_DIV, MD_REM: begin
        s1 = issue_pkt.rs1_value[31];
        s2 = issue_pkt.rs2_value[31];
      end
      MD_MULHSU: s1 = issue_pkt.rs1_value[31];
      default: ;
    endcase
    mag1     = s1 ? -issue_pkt.rs1_value : issue_pkt.rs1_value;
    mag2     = s2 ? -issue_pkt.rs2_value : issue_pkt.rs2_value;
    dz_value = issue_pkt.fu_opcode[1] ? issue_pkt.rs1_value : 32'hFFFF_FFFF;
  end

  // One shift-add / restoring-divide step, plus sign fix-up applied on the final step
  always_comb begin
    acc_nxt  = opb[0] ? acc + mcand : acc;
    prod_fin = neg_res ? (~acc_nxt + 64'd1) : acc_nxt;
    rem_sh   = {prem, opb[31]};
    q_bit    = (rem_sh >= {1'b0, dsr});
    rem_nxt  = q_bit ? 32'(rem_sh - {1'b0, dsr}) : rem_sh[31:0];
    quo_nxt  = {opb[30:0], q_bit};
    quo_fin  = neg_res ? -quo_nxt : quo_nxt;
    rem_fin  = neg_rem ? -rem_nxt : rem_nxt;
  end

  // Control FSM and datapath registers; outputs are registered
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      issue_ready <= 1'b1;
      cdb_valid   <= 1'b0;
      cdb_out     <= '0;
      cnt         <= '0;
      acc         <= '0;
      mcand       <= '0;
      opb         <= '0;
      prem        <= '0;
      dsr         <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      pkt         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            pkt         <= issue_pkt;
            cnt         <= '0;
            issue_ready <= 1'b0;
            neg_res     <= s1 ^ s2;
            neg_rem     <= s1;
            acc         <= '0;
            mcand       <= {32'd0, mag1};
            opb         <= is_div ? mag1 : mag2;
            dsr         <= mag2;
            prem        <= '0;
            if (!is_div) begin
              state <= S_MUL;
            end else if (div_zero) begin
              state     <= S_DONE;
              cdb_valid <= 1'b1;
              cdb_out   <= make_cdb(issue_pkt, dz_value);
            end else begin
              state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          acc   <= acc_nxt;
          mcand <= mcand << 1;
          opb   <= opb >> 1;
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state     <= S_DONE;
            cdb_valid <= 1'b1;
            cdb_out   <= make_cdb(pkt, (pkt.fu_opcode == MD_MUL) ? prod_fin[31:0] : prod_fin[63:32]);
          end
        end
        S_DIV: begin
          prem <= rem_nxt;
          opb  <= quo_nxt;
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state     <= S_DONE;
            cdb_valid <= 1'b1;
            cdb_out   <= make_cdb(pkt, pkt.fu_opcode[1] ? rem_fin : quo_fin);
          end
        end
        S_DONE: begin
          cdb_valid   <= 1'b0;
          issue_ready <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
